// File: rtl/ecp_clk_pkg.sv
// Shared definitions for the ECP5 PLL lock supervisor: the debug-visible state
// codes and default timing derived from the 25 MHz reference clock.
package ecp_clk_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int REF_CLK_HZ        = 25_000_000;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = REF_CLK_HZ / 100;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_CNT_W         = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchroniser with asynchronous active-low reset;
// the output is 0 while in reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences ECP5 PLL reset, lock wait with timeout/retry and lock-stability
// qualification, and produces a qualified reset for the PLL clock domain.
module pll_lock_supervisor
  import ecp_clk_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             locked_async,
  input  logic             retry,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [2:0]       state
);

  localparam int TMR_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_RETRIES);

  logic             w_locked_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] w_retry_nxt;
  logic [CNT_W-1:0] w_retry_inc;
  logic [CNT_W-1:0] r_loss_cnt;
  logic [CNT_W-1:0] w_loss_nxt;
  logic [CNT_W-1:0] w_loss_inc;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fail;

  sync_2ff u_lock_sync (
    .i_clk   (clkin),
    .i_rst_n (rstn),
    .i_d     (locked_async),
    .o_q     (w_locked_s)
  );

  assign w_retry_inc = (r_retry_cnt == '1) ? r_retry_cnt : r_retry_cnt + CNT_W'(1);
  assign w_loss_inc  = (r_loss_cnt == '1)  ? r_loss_cnt  : r_loss_cnt + CNT_W'(1);

  // One shared timer serves every timed state; it is cleared on each transition.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TMR_W'(1);
    w_retry_nxt = r_retry_cnt;
    w_loss_nxt  = r_loss_cnt;
    case (r_state)
      ST_RESET_PLL: begin
        if (r_timer == TMR_W'(RST_CYCLES - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
          w_retry_nxt = w_retry_inc;
          w_timer_nxt = '0;
          w_state_nxt = (w_retry_inc >= MAX_R) ? ST_FAIL : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == TMR_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end
      end
      ST_RUN: begin
        w_timer_nxt = '0;
        if (!w_locked_s) begin
          w_state_nxt = ST_RESET_PLL;
          w_loss_nxt  = w_loss_inc;
        end
      end
      ST_FAIL: begin
        w_timer_nxt = '0;
        if (retry) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_RESET_PLL;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_RESET_PLL;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_loss_cnt  <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios with literal
// expectations plus randomized lock/retry traffic against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RST_C  = 4;
  localparam int LOCK_T = 20;
  localparam int STAB_C = 8;
  localparam int MAX_R  = 2;
  localparam int CW     = 8;
  localparam int SAT    = (1 << CW) - 1;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic          clkin = 1'b0;
  logic          rstn = 1'b0;
  logic          locked_async = 1'b0;
  logic          retry = 1'b0;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          ready;
  logic          fail;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] loss_cnt;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  int edgeNo = 0;

  int mPhase = PH_RESET;
  int mEl = 0;
  int mRetries = 0;
  int mLoss = 0;
  int lockHist[$] = '{0, 0};

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (LOCK_T),
    .STABLE_CYCLES (STAB_C),
    .MAX_RETRIES   (MAX_R),
    .CNT_W         (CW)
  ) dut (
    .clkin        (clkin),
    .rstn         (rstn),
    .locked_async (locked_async),
    .retry        (retry),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .loss_cnt     (loss_cnt),
    .state        (state)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin or negedge rstn) begin
    if (!rstn) edgeNo <= 0;
    else       edgeNo <= edgeNo + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic rty);
    locked_async = lock;
    retry = rty;
  endtask

  // Model: the synchroniser is a two-deep history; phases count elapsed edges.
  task automatic modelReset();
    mPhase = PH_RESET;
    mEl = 0;
    mRetries = 0;
    mLoss = 0;
    lockHist = '{0, 0};
  endtask

  task automatic modelStep();
    int seen;
    seen = lockHist.pop_front();
    lockHist.push_back(int'(locked_async));
    case (mPhase)
      PH_RESET: begin
        mEl++;
        if (mEl == RST_C) begin mPhase = PH_WAIT; mEl = 0; end
      end
      PH_WAIT: begin
        if (seen != 0) begin
          mPhase = PH_STABLE; mEl = 0;
        end else begin
          mEl++;
          if (mEl == LOCK_T) begin
            mRetries = (mRetries < SAT) ? mRetries + 1 : SAT;
            mPhase = (mRetries >= MAX_R) ? PH_FAIL : PH_RESET;
            mEl = 0;
          end
        end
      end
      PH_STABLE: begin
        if (seen == 0) begin
          mPhase = PH_WAIT; mEl = 0;
        end else begin
          mEl++;
          if (mEl == STAB_C) begin mPhase = PH_RUN; mEl = 0; mRetries = 0; end
        end
      end
      PH_RUN: begin
        if (seen == 0) begin
          mLoss = (mLoss < SAT) ? mLoss + 1 : SAT;
          mPhase = PH_RESET; mEl = 0;
        end
      end
      default: begin
        if (retry) begin mPhase = PH_RESET; mEl = 0; mRetries = 0; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clkin or negedge rstn);
    if (!rstn) modelReset();
    else       modelStep();
  end

  initial forever begin
    @(negedge clkin);
    if (checkEn) begin
      checkOutput("model_state", state, mPhase);
      checkOutput("model_pll_rst", pll_rst, (mPhase == PH_RESET || mPhase == PH_FAIL) ? 1 : 0);
      checkOutput("model_sys_rst_n", sys_rst_n, (mPhase == PH_RUN) ? 1 : 0);
      checkOutput("model_ready", ready, (mPhase == PH_RUN) ? 1 : 0);
      checkOutput("model_fail", fail, (mPhase == PH_FAIL) ? 1 : 0);
      checkOutput("model_retry_cnt", retry_cnt, mRetries);
      checkOutput("model_loss_cnt", loss_cnt, mLoss);
    end
  end

  task automatic untilEdge(input int k);
    while (edgeNo < k) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic releaseReset();
    @(negedge clkin);
    rstn = 1'b1;
  endtask

  task automatic holdReset();
    rstn = 1'b0;
    repeat (2) @(posedge clkin);
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(posedge clkin);
      #1;
      n++;
    end
    checkOutput("wait_ready", ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clkin);
    #1 checkEn = 1'b1;
    checkOutput("reset_pll_rst", pll_rst, 1);
    checkOutput("reset_sys_rst_n", sys_rst_n, 0);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_loss_cnt", loss_cnt, 0);

    // Scenario 1: lock held from reset.
    applyStimulus(1'b1, 1'b0);
    releaseReset();
    untilEdge(3);  checkOutput("s1_pll_rst_e3", pll_rst, 1);
    untilEdge(4);  checkOutput("s1_pll_rst_e4", pll_rst, 0);
                   checkOutput("s1_state_e4", state, PH_WAIT);
    untilEdge(5);  checkOutput("s1_state_e5", state, PH_STABLE);
    untilEdge(12); checkOutput("s1_sys_rst_n_e12", sys_rst_n, 0);
    untilEdge(13); checkOutput("s1_sys_rst_n_e13", sys_rst_n, 1);
                   checkOutput("s1_ready_e13", ready, 1);
                   checkOutput("s1_retry_cnt", retry_cnt, 0);

    // Scenario 3: lock lost in RUN for three cycles.
    untilEdge(15);
    @(negedge clkin); applyStimulus(1'b0, 1'b0);
    untilEdge(17); checkOutput("s3_sys_rst_n_e17", sys_rst_n, 1);
    untilEdge(18); checkOutput("s3_sys_rst_n_e18", sys_rst_n, 0);
                   checkOutput("s3_loss_cnt", loss_cnt, 1);
                   checkOutput("s3_pll_rst", pll_rst, 1);
    @(negedge clkin); applyStimulus(1'b1, 1'b0);
    untilEdge(30); checkOutput("s3_ready_e30", ready, 0);
    untilEdge(31); checkOutput("s3_ready_e31", ready, 1);

    // Scenario 6a: asynchronous reset while in RUN.
    untilEdge(33);
    #1 rstn = 1'b0;
    #1;
    checkOutput("s6_async_sys_rst_n", sys_rst_n, 0);
    checkOutput("s6_async_ready", ready, 0);
    checkOutput("s6_async_loss_cnt", loss_cnt, 0);
    checkOutput("s6_async_state", state, 0);
    repeat (2) @(posedge clkin);
    releaseReset();
    untilEdge(13); checkOutput("s6_rerun_ready", ready, 1);

    // Scenario 4: one-cycle glitch at stable count 5.
    holdReset();
    applyStimulus(1'b1, 1'b0);
    releaseReset();
    untilEdge(8);
    @(negedge clkin); applyStimulus(1'b0, 1'b0);
    @(negedge clkin); applyStimulus(1'b1, 1'b0);
    untilEdge(11); checkOutput("s4_state_e11", state, PH_WAIT);
                   checkOutput("s4_sys_rst_n_e11", sys_rst_n, 0);
    untilEdge(12); checkOutput("s4_state_e12", state, PH_STABLE);
    untilEdge(19); checkOutput("s4_ready_e19", ready, 0);
    untilEdge(20); checkOutput("s4_ready_e20", ready, 1);

    // Scenario 2: no lock, two timeouts into FAIL, then retry.
    holdReset();
    applyStimulus(1'b0, 1'b0);
    releaseReset();
    untilEdge(24); checkOutput("s2_retry_cnt_e24", retry_cnt, 1);
                   checkOutput("s2_state_e24", state, PH_RESET);
    untilEdge(48); checkOutput("s2_state_e48", state, PH_FAIL);
                   checkOutput("s2_fail_e48", fail, 1);
                   checkOutput("s2_retry_cnt_e48", retry_cnt, 2);
    untilEdge(52); checkOutput("s2_state_e52", state, PH_FAIL);
    @(negedge clkin); applyStimulus(1'b0, 1'b1);
    untilEdge(53); checkOutput("s2_state_after_retry", state, PH_RESET);
                   checkOutput("s2_fail_after_retry", fail, 0);
                   checkOutput("s2_retry_cnt_after_retry", retry_cnt, 0);
    @(negedge clkin); applyStimulus(1'b0, 1'b0);

    // Scenario 5: lock seen exactly on the second attempt's timeout cycle.
    holdReset();
    applyStimulus(1'b0, 1'b0);
    releaseReset();
    untilEdge(45);
    @(negedge clkin); applyStimulus(1'b1, 1'b0);
    untilEdge(47); checkOutput("s5_state_e47", state, PH_WAIT);
    untilEdge(48); checkOutput("s5_state_e48", state, PH_STABLE);
                   checkOutput("s5_retry_cnt_e48", retry_cnt, 1);
    untilEdge(56); checkOutput("s5_ready_e56", ready, 1);
                   checkOutput("s5_retry_cnt_e56", retry_cnt, 0);

    // Scenario 6b: 300 forced losses saturate loss_cnt.
    for (int i = 0; i < 300; i++) begin
      waitReady(100);
      @(negedge clkin); applyStimulus(1'b0, 1'b0);
      @(negedge clkin); applyStimulus(1'b1, 1'b0);
      repeat (3) @(posedge clkin);
      #1;
    end
    checkOutput("s6_loss_cnt_saturated", loss_cnt, SAT);

    // Randomized lock quality and retry pulses.
    for (int seg = 0; seg < 20; seg++) begin
      int p;
      case ($urandom_range(0, 4))
        0:       p = 100;
        1:       p = 97;
        2:       p = 70;
        3:       p = 0;
        default: p = 100;
      endcase
      for (int c = 0; c < 150; c++) begin
        @(negedge clkin);
        applyStimulus(($urandom_range(0, 99) < p), ($urandom_range(0, 15) == 0));
      end
    end
    @(negedge clkin); applyStimulus(1'b1, 1'b0);
    repeat (4) @(posedge clkin);
    @(negedge clkin);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer side of the ECP5 PLL lock interface. Drives the PLL RST pin and watches its asynchronous LOCK output.
- Sequences PLL reset, lock wait with timeout and retries, and a lock-stability qualification window.
- Generates a qualified system reset for logic clocked from the PLL output.
- Runs entirely on the 25 MHz reference clock that feeds the PLL, so it keeps working while the PLL is unlocked.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high on each PLL reset attempt (min 2).
- LOCK_TIMEOUT, 250000: cycles allowed in WAIT_LOCK before an attempt fails (10 ms at 25 MHz).
- STABLE_CYCLES, 1024: consecutive synced-locked cycles required before release.
- MAX_RETRIES, 4: consecutive timeouts before entering FAIL (min 1).
- CNT_W, 8: width of the status counters.

Ports:
- clkin  in  1  25 MHz reference clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- locked_async  in  1  PLL LOCK output, asynchronous to clkin.
- retry  in  1  one-cycle pulse; leaves FAIL. Ignored in all other states.
- pll_rst  out  1  to PLL RST, active high.
- sys_rst_n  out  1  active-low reset for the PLL clock domain. Consumer re-synchronises the deassertion into that domain.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  CNT_W  consecutive lock timeouts since the last RUN entry.
- loss_cnt  out  CNT_W  lock-loss events while in RUN; saturating.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = RESET_PLL.
  - pll_rst = 1, sys_rst_n = 0, ready = 0, fail = 0.
  - retry_cnt = 0, loss_cnt = 0, all timers = 0, both sync flops = 0.
- locked_async passes through a 2-flop synchroniser to give locked_s; latency is 2 edges. No other input is synchronised; retry is assumed synchronous to clkin.
- All outputs are registered. Outputs change on the edge that enters a state.
- State encoding: RESET_PLL = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, FAIL = 4.
- RESET_PLL:
  - pll_rst = 1, sys_rst_n = 0.
  - Timer counts RST_CYCLES edges, then transitions to WAIT_LOCK and clears the timer.
  - locked_s is ignored in this state.
- WAIT_LOCK:
  - pll_rst = 0.
  - If locked_s = 1, go to STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1: increment retry_cnt (saturating). If the new value is at least MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - Counter increments on each cycle with locked_s = 1.
  - Any locked_s = 0 cycle returns to WAIT_LOCK with its timer restarted. No retry_cnt increment.
  - When the counter reaches STABLE_CYCLES, go to RUN: sys_rst_n = 1, ready = 1, retry_cnt cleared.
- RUN:
  - On locked_s = 0, sys_rst_n = 0 and ready = 0 on the next edge.
  - loss_cnt increments (saturating at all-ones) and the FSM goes to RESET_PLL.
- FAIL:
  - pll_rst = 1, sys_rst_n = 0, fail = 1.
  - A retry pulse returns to RESET_PLL with retry_cnt cleared and fail = 0.
  - loss_cnt is preserved.
- rstn asserted mid-operation aborts immediately to the reset values. sys_rst_n drops asynchronously.
- Timers are sized $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. No wrap is possible.
- sys_rst_n never glitches high: it is set only on the STABLE→RUN transition.

Decomposition:
- Shared package ecp_clk_pkg holds:
  - the state enum (codes above), so debug logic can decode state;
  - default timing constants derived from a 25 MHz reference.
- One natural sub-module: sync_2ff, a generic 2-flop bit synchroniser with async active-low reset. It is reused for the consumer-side sys_rst_n deassertion synchroniser.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2. Edges are counted from rstn release.
1. locked_async held at 1 from reset → pll_rst high through edge 4, WAIT_LOCK for 1 cycle, sys_rst_n and ready go high after edge 13; retry_cnt = 0.
2. locked_async held at 0 → two timeouts, then fail = 1, state = 4, pll_rst = 1, retry_cnt = 2. A retry pulse → state = 0, fail = 0, retry_cnt = 0.
3. Lock reaches RUN, then locked_async drops for 3 cycles → sys_rst_n low 3 edges after the drop (2 sync + 1), loss_cnt = 1, pll_rst high again. Lock restored → RUN again.
4. In STABLE, locked_async glitches low for 1 cycle at stable count 5 → returns to WAIT_LOCK; sys_rst_n stays 0; RUN reached only after 8 further consecutive locked cycles.
5. Lock rises exactly on the timeout cycle → enters STABLE; retry_cnt unchanged.
6. rstn pulsed low during RUN → sys_rst_n goes 0 without waiting for a clock edge, loss_cnt = 0, full sequence repeats. Separately, 300 forced losses → loss_cnt saturates at 255.
